dense_4_sequencer: RTL and testbench

DENSE_4_SEQUENCER -- requirements
Module: dense_4_sequencer

---
 rtl/dense_4_23_12.sv | 41 ++++
 rtl/dense_4_seq_pkg.sv | 39 +++
 rtl/dense_4_mac.sv | 32 +++
 rtl/dense_4_sequencer.sv | 129 ++++++++++++
 tb/tb_dense_4_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dense_4_23_12.sv
// Trained dense_4 coefficients (32 inputs x 5 neurons) and biases, integer LSB units of Q(23,11).
package dense_4_23_12;

   localparam int weights [32][5] = '{
      '{ -25,  646, -611,  134, -218},
      '{ 112,  388, -402,  -57,   91},
      '{-301,  275, -188,  220,  -14},
      '{  47,  512,  -95, -310,  166},
      '{ 209,  143, -477,   18, -250},
      '{ -88,  401,  -36,  295,   73},
      '{ 156,  -62, -529, -141,  310},
      '{-199,  333, -120,   77,  -45},
      '{  64,  219, -384,  188,  127},
      '{ -12,  470, -266, -203,  -98},
      '{ 285,   91,  -58,   46,  231},
      '{-147,  358, -442,   -9,   60},
      '{  31,  207, -173,  264, -187},
      '{ 178,  529, -301, -118,   14},
      '{-240,   66,  -97,  153,  289},
      '{  93,  312, -515,  -72, -133},
      '{ -55,  248,  -14,  201,   45},
      '{ 137,  185, -368, -260,  178},
      '{  -6,  437, -229,   99,  -61},
      '{ 222,  -34, -146,   12,  204},
      '{-173,  296, -407, -185,  -22},
      '{  58,  164,  -81,  240,  119},
      '{ 104,  381, -290,  -33, -176},
      '{-131,  229, -455,  170,   88},
      '{  19,  117,  -22,  -97,  263},
      '{ 246,  350, -339,   56,  -39},
      '{ -92,   41, -176,  213,  150},
      '{  73,  268, -420, -146,  -84},
      '{-215,  193,  -67,   31,  197},
      '{ 166,  402, -248,  128, -117},
      '{ -37,   88, -501, -211,   35},
      '{ 121,  315, -133,   84,  242}
   };

   localparam int bias [5] = '{-128, -129, -144, 168, 441};

endpackage

// File: rtl/dense_4_seq_pkg.sv
// Shared sizes, FSM state encoding and output saturation for the dense_4 layer sequencer.
package dense_4_seq_pkg;

   localparam int N_IN  = 32;
   localparam int N_OUT = 5;
   localparam int DW    = 23;
   localparam int NFRAC = 11;
   localparam int ACC_W = 52;
   localparam int PW    = 2 * DW;
   localparam int IDX_W = $clog2(N_IN);
   localparam int N_W   = $clog2(N_OUT);

   localparam logic [IDX_W-1:0] LAST_IN = IDX_W'(N_IN - 1);
   localparam logic [N_W-1:0]   LAST_N  = N_W'(N_OUT - 1);

   localparam logic signed [DW-1:0]    SAT_MAX     = 23'sh3FFFFF;
   localparam logic signed [DW-1:0]    SAT_MIN     = 23'sh400000;
   localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = 52'sd4194303;
   localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = -52'sd4194304;

   typedef enum logic [1:0] {
      LOAD,
      MAC,
      FINAL,
      OUT
   } state_t;

   // Clamp an already-rescaled accumulator value into the signed 23-bit output range.
   function automatic logic signed [DW-1:0] sat23(input logic signed [ACC_W-1:0] v);
      if (v > ACC_SAT_MAX) begin
         return SAT_MAX;
      end else if (v < ACC_SAT_MIN) begin
         return SAT_MIN;
      end else begin
         return v[DW-1:0];
      end
   endfunction

endpackage

// File: rtl/dense_4_mac.sv
// Single shared multiply-accumulate: loads a bias pre-scaled to product units, accumulates, or holds.
module dense_4_mac
   import dense_4_seq_pkg::*;
(
   input  logic                    clk,
   input  logic                    load,
   input  logic                    en,
   input  logic signed [DW-1:0]    bias,
   input  logic signed [DW-1:0]    a,
   input  logic signed [DW-1:0]    b,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [PW-1:0]    prod_p0;
   logic signed [ACC_W-1:0] prod_ext_p0;
   logic signed [ACC_W-1:0] bias_ext_p0;

   // Full-precision product; 52-bit accumulator leaves 6 guard bits over 32 terms plus bias.
   assign prod_p0     = PW'(a) * PW'(b);
   assign prod_ext_p0 = ACC_W'(prod_p0);
   assign bias_ext_p0 = ACC_W'(bias) <<< NFRAC;

   // ---- stage p1: accumulator register
   always_ff @(posedge clk) begin
      if (load) begin
         acc <= bias_ext_p0;
      end else if (en) begin
         acc <= acc + prod_ext_p0;
      end
   end

endmodule

// File: rtl/dense_4_sequencer.sv
// dense_4 layer sequencer: buffers 32 features, time-multiplexes one MAC over 5 neurons, streams results.
module dense_4_sequencer
   import dense_4_seq_pkg::*, dense_4_23_12::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [DW-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic signed [DW-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy
);

   state_t               state;
   state_t               state_nxt;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     i;
   logic [N_W-1:0]       n;
   logic [N_W-1:0]       k;
   logic [N_W-1:0]       bias_sel;
   logic                 in_hs;
   logic                 out_hs;
   logic                 mac_load;
   logic                 mac_en;
   logic signed [DW-1:0] mac_a;
   logic signed [DW-1:0] mac_b;
   logic signed [DW-1:0] mac_bias;
   logic signed [ACC_W-1:0] acc;
   logic signed [DW-1:0] x   [N_IN];
   logic signed [DW-1:0] res [N_OUT];

   // Handshake outputs are forced low during reset so a mid-vector reset never leaks a beat.
   assign in_ready  = !reset && (state == LOAD);
   assign out_valid = !reset && (state == OUT);
   assign out_last  = out_valid && (k == LAST_N);
   assign out_data  = out_valid ? res[k] : '0;
   assign busy      = !reset && ((state != LOAD) || (idx != '0));

   assign in_hs  = in_ready && in_valid;
   assign out_hs = out_valid && out_ready;

   assign mac_a    = x[i];
   assign mac_b    = DW'(weights[i][n]);
   assign mac_bias = DW'(bias[bias_sel]);

   always_comb begin
      state_nxt = state;
      mac_load  = 1'b0;
      mac_en    = 1'b0;
      bias_sel  = '0;
      unique case (state)
         LOAD: begin
            if (in_hs && (idx == LAST_IN)) begin
               state_nxt = MAC;
               mac_load  = 1'b1;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (i == LAST_IN) begin
               state_nxt = FINAL;
            end
         end
         FINAL: begin
            if (n != LAST_N) begin
               state_nxt = MAC;
               mac_load  = 1'b1;
               bias_sel  = n + 1'b1;
            end else begin
               state_nxt = OUT;
            end
         end
         OUT: begin
            if (out_hs && (k == LAST_N)) begin
               state_nxt = LOAD;
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD;
         idx   <= '0;
         i     <= '0;
         n     <= '0;
         k     <= '0;
      end else begin
         state <= state_nxt;
         if (in_hs) begin
            idx <= idx + 1'b1;
         end
         if (state == MAC) begin
            i <= i + 1'b1;
         end
         if (state == FINAL) begin
            n <= (n == LAST_N) ? '0 : n + 1'b1;
         end
         if (out_hs) begin
            k <= (k == LAST_N) ? '0 : k + 1'b1;
         end
      end
   end

   // ---- stage p0: feature buffer and rescaled neuron results
   always_ff @(posedge clk) begin
      if (in_hs) begin
         x[idx] <= in_data;
      end
      if (state == FINAL) begin
         res[n] <= sat23(acc >>> NFRAC);
      end
   end

   dense_4_mac u_mac (
      .clk  (clk),
      .load (mac_load),
      .en   (mac_en),
      .bias (mac_bias),
      .a    (mac_a),
      .b    (mac_b),
      .acc  (acc)
   );

endmodule

// File: tb/tb_dense_4_sequencer.sv
// Scoreboard bench for dense_4_sequencer: stimulus pushes expected beats, a monitor pops and compares.
module tb_dense_4_sequencer;
   import dense_4_23_12::*;

   typedef logic signed [22:0] vec_t [32];
   typedef struct { int data; bit last; } exp_t;

   logic clk = 1'b0;
   logic reset, in_valid, in_ready, out_valid, out_ready, out_last, busy;
   logic signed [22:0] in_data, out_data;

   exp_t exp_q[$];
   int   n_checks = 0, n_pass = 0;
   int   cyc = 0, last_in_cyc = 0, beats_done = 0, held_d = 0;
   bit   seen_first = 0, held_v = 0, held_l = 0, ready_due = 0;
   bit   stall_req = 0, rnd_ready = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dense_4_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   task automatic check(input string nm, input longint act, input longint req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
   endtask

   // Reference: each neuron is bias + sum(x*w) in Q11, floored back to Q11 and clamped.
   task automatic push_model(input vec_t v);
      longint s;
      for (int nn = 0; nn < 5; nn++) begin
         s = longint'(bias[nn]) * 2048;
         for (int ii = 0; ii < 32; ii++) s += longint'(v[ii]) * longint'(weights[ii][nn]);
         s = s >>> 11;
         if (s > 4194303) s = 4194303;
         if (s < -4194304) s = -4194304;
         exp_q.push_back('{data: int'(s), last: (nn == 4)});
      end
   endtask

   task automatic push_list(input int e0, input int e1, input int e2, input int e3, input int e4);
      exp_q.push_back('{data: e0, last: 1'b0});
      exp_q.push_back('{data: e1, last: 1'b0});
      exp_q.push_back('{data: e2, last: 1'b0});
      exp_q.push_back('{data: e3, last: 1'b0});
      exp_q.push_back('{data: e4, last: 1'b1});
   endtask

   task automatic send_vec(input vec_t v, input int gap_pct);
      int t;
      bit ok;
      for (int j = 0; j < 32; j++) begin
         while (int'($urandom_range(0, 99)) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = v[j];
         t  = 0;
         ok = 1'b0;
         while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            t++;
            if (!ok && t > 2000) begin
               check("send_timeout", t, 0);
               $display("%0d/%0d checks passed", n_pass, n_checks);
               $fatal(1, "input side stalled");
            end
         end
      end
      last_in_cyc = cyc;
      in_valid    = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain_empty", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic rand_vec(output vec_t v, input int mode);
      for (int j = 0; j < 32; j++) begin
         case (mode)
            0:       v[j] = $signed(23'($urandom));
            1:       v[j] = $signed(23'($urandom_range(0, 16383))) - 23'sd8192;
            default: v[j] = ($urandom_range(0, 1) != 0) ? 23'sh400000 : 23'sh3FFFFF;
         endcase
      end
   endtask

   // Monitor: latency, hold stability, scoreboard pop and in_ready return.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            seen_first = 0; held_v = 0; ready_due = 0; beats_done = 0;
         end else begin
            if (ready_due) begin
               check("in_ready_return", in_ready, 1);
               ready_due = 0;
            end
            if (out_valid) begin
               check("in_ready_during_out", in_ready, 0);
               if (!seen_first) begin
                  check("latency", cyc - last_in_cyc, 165);
                  seen_first = 1;
               end
               if (held_v) begin
                  check("hold_data", int'(out_data), held_d);
                  check("hold_last", out_last, held_l);
               end
               if (out_ready) begin
                  held_v = 0;
                  if (exp_q.size() == 0) begin
                     check("unexpected_beat", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     check("out_data", int'(out_data), e.data);
                     check("out_last", out_last, e.last);
                  end
                  beats_done++;
                  if (out_last) begin
                     seen_first = 0; ready_due = 1; beats_done = 0;
                  end
               end else begin
                  held_v = 1; held_d = int'(out_data); held_l = out_last;
               end
            end else begin
               held_v = 0;
            end
         end
      end
   end

   // Downstream ready: always-on or random, with an optional 10-cycle stall on beat 2.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (stall_req && out_valid && beats_done == 2) begin
            out_ready = 1'b0;
            repeat (10) begin @(posedge clk); #1; end
            stall_req = 0;
         end
         out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   initial begin
      vec_t v, v2;
      reset = 1'b1; in_valid = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_busy", busy, 0);
      @(posedge clk); #1;

      foreach (v[j]) v[j] = '0;
      push_list(-128, -129, -144, 168, 441);
      send_vec(v, 0);
      drain();

      v[0] = 23'sd2048;
      push_list(-153, 517, -755, 302, 223);
      send_vec(v, 0);
      drain();

      foreach (v[j]) v[j] = 23'sh3FFFFF;
      push_model(v);
      send_vec(v, 20);
      drain();

      rnd_ready = 1; stall_req = 1;
      rand_vec(v, 1);
      push_model(v);
      send_vec(v, 30);
      drain();
      check("stall_applied", stall_req, 0);
      rnd_ready = 0;

      rand_vec(v, 0);
      push_model(v);
      send_vec(v, 0);
      repeat (50) @(posedge clk);
      #1;
      check("busy_mac", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      exp_q.delete();
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("after_rst_out_valid", out_valid, 0);
      check("after_rst_busy", busy, 0);
      check("after_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      foreach (v[j]) v[j] = '0;
      push_list(-128, -129, -144, 168, 441);
      send_vec(v, 10);
      drain();

      rand_vec(v, 1);
      rand_vec(v2, 0);
      push_model(v);
      send_vec(v, 0);
      push_model(v2);
      send_vec(v2, 0);
      drain();

      rnd_ready = 1;
      for (int r = 0; r < 3; r++) begin
         rand_vec(v, r);
         push_model(v);
         send_vec(v, 25);
         drain();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
